bcd_count_sequencer: RTL and testbench
======================================

Name: bcd_count_sequencer

Overview:
- Controller that owns a 16-bit, 4-digit packed-BCD count register.
- Sequences an external 4-digit BCD incrementer: presents the current count and an enable, then captures the incremented result on a prescaled tick.
- Provides start/stop/clear control, terminal-count detection, and a valid/ready update handshake so the display writer redraws only when the count changes.

Parameters:
- PRESCALE, 4, clock cycles per count tick while running; must be >= 1.
- TERMINAL, 16'h9999, packed-BCD terminal value; a non-BCD value never matches.
- WRAP, 1, 1 = on terminal tick load 16'h0000 and keep running; 0 = hold at TERMINAL and enter DONE.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; begin or resume counting.
- stop  input  1  level; pause counting.
- clear  input  1  level; zero the count and prescaler, return to IDLE.
- inc_bcd_in  output  16  operand to the external incrementer; always equals count.
- inc_enable  output  1  increment enable to the external incrementer.
- inc_bcd_out  input  16  combinational result from the external incrementer.
- count  output  16  current packed-BCD count; digit 3 is in [15:12].
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- upd_valid  output  1  count has changed since the last accepted update.
- upd_ready  input  1  display writer accepts the update.

Behaviour:
- Reset (rst=1 at a clock edge) overrides everything:
  - state=IDLE, count=16'h0000, prescaler=0.
  - running=0, done=0, upd_valid=0.
- States: IDLE, RUN, DONE. running and done are registered decodes of the state.
- Command priority each cycle: clear > stop > start.
- clear, from any state: count<=0, prescaler<=0, state<=IDLE, upd_valid<=1.
- stop in RUN: state<=IDLE; the prescaler value is retained (pause, not reset).
- start in IDLE: state<=RUN; counting resumes from the retained prescaler value.
- start in DONE is ignored; only clear or rst leaves DONE.
- Prescaler in RUN:
  - increments each cycle, wrapping from PRESCALE-1 to 0.
  - tick = (state==RUN) && (prescaler==PRESCALE-1).
  - width is $clog2(PRESCALE), minimum 1 bit.
  - PRESCALE=1 gives a tick every RUN cycle.
- inc_bcd_in = count, combinational.
- inc_enable = tick, combinational. It is 0 outside RUN and in any cycle where stop or clear is asserted.
- On tick, when count != TERMINAL: count <= inc_bcd_out. The result is visible on count one cycle after the tick edge.
- On tick, when count == TERMINAL:
  - WRAP=1: count <= 16'h0000, stay in RUN.
  - WRAP=0: count unchanged, state <= DONE, no further increments.
- If TERMINAL is 16'h9999 and WRAP=1, the natural 9999->0000 rollover matches the explicit wrap.
- Update handshake:
  - upd_valid is set on the edge after any count change: tick-update, wrap, or clear.
  - Entering DONE without a count change does not set upd_valid.
  - upd_valid clears when upd_valid && upd_ready and no new change occurs in the same cycle.
  - A change coinciding with acceptance keeps upd_valid=1.
  - Semantics are latest-value: intermediate counts may be skipped while the writer stalls; counting never stalls.
- The incrementer is purely combinational, so there is no back-pressure on the datapath.
- Count values are always valid BCD: they come only from reset, clear, or inc_bcd_out of a valid BCD input.

Test Plan:
- Reset, then start=1 with PRESCALE=4 and upd_ready=1:
  - count changes 0000->0001 exactly 4 cycles after RUN entry, then every 4 cycles.
  - inc_enable pulses are 1 cycle wide.
- Decade carries: starting from clear, run to 0009->0010, 0099->0100 and 0999->1000; each carries correctly in one tick.
- Terminal, WRAP=1: count reaches 9999, then 0000 on the next tick; running stays 1 and upd_valid pulses.
- Terminal, WRAP=0, TERMINAL=16'h0012:
  - count stops at 0012 and done=1; running=0 the cycle after the terminal tick.
  - start has no effect; clear gives count=0000, state IDLE, upd_valid=1.
- Pause and resume: stop asserted mid-period with prescaler=2, then start. The next tick arrives after 1 cycle of RUN (prescaler retained). Asserting stop and start together results in IDLE.
- Handshake stall: hold upd_ready=0 across 3 ticks.
  - upd_valid stays 1 and count shows the latest value (e.g. 0003).
  - A single upd_ready=1 cycle without a coincident tick drops upd_valid.
  - A ready cycle coincident with a tick keeps upd_valid=1.
- Reset mid-RUN with count=0457: count=0000, upd_valid=0 and IDLE on the next edge; inc_enable=0.

Source files
------------

// File: rtl/bcd_count_sequencer.sv
// bcd_count_sequencer
// Owns a 4-digit packed-BCD count. It presents the count to an external
// combinational BCD incrementer and captures the incremented result on every
// prescaled tick. It also handles start/stop/clear, terminal-count detection
// and a latest-value valid/ready update handshake for a display writer.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        level, begin or resume counting
//   stop         level, pause counting (prescaler phase retained)
//   clear        level, zero count and prescaler, back to IDLE
//   inc_bcd_in   operand to the external incrementer (always equals count)
//   inc_enable   increment enable to the external incrementer (the tick)
//   inc_bcd_out  combinational result from the external incrementer
//   count        current packed-BCD count, digit 3 in [15:12]
//   running      high in RUN (registered)
//   done         high in DONE (registered)
//   upd_valid    count changed since the last accepted update
//   upd_ready    display writer accepts the update
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped or paused; count and prescaler phase held
// RUN   | prescaler advancing, count captured from incrementer on tick
// DONE  | held at TERMINAL (WRAP=0 only); left only by clear or rst
module bcd_count_sequencer #(
  parameter int          PRESCALE = 4,
  parameter logic [15:0] TERMINAL = 16'h9999,
  parameter bit          WRAP     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [15:0] inc_bcd_in,
  output logic        inc_enable,
  input  logic [15:0] inc_bcd_out,
  output logic [15:0] count,
  output logic        running,
  output logic        done,
  output logic        upd_valid,
  input  logic        upd_ready
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_nxt;
  logic [15:0]   count_nxt;
  logic          cnt_change;
  logic          tick;
  logic          at_term;

  // Count is always valid BCD, so a non-BCD TERMINAL can never match here.
  assign at_term = (count == TERMINAL);

  // State register; running/done are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      done    <= (state_nxt == ST_DONE);
    end
  end

  // Next-state logic, command priority clear > stop > start.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else if (stop) begin
      if (state == ST_RUN) state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = ST_RUN;
        ST_RUN:  if (tick && at_term && !WRAP) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs. A cycle carrying stop or clear never ticks, so the incrementer
  // result is only consumed when the count is actually going to advance.
  always_comb begin
    tick       = (state == ST_RUN) && (prescaler == PS_LAST) && !stop && !clear;
    inc_enable = tick;
    inc_bcd_in = count;
  end

  // Datapath next values.
  always_comb begin
    prescaler_nxt = prescaler;
    count_nxt     = count;
    cnt_change    = 1'b0;
    if (clear) begin
      prescaler_nxt = '0;
      count_nxt     = 16'h0000;
      cnt_change    = 1'b1;
    end else if ((state == ST_RUN) && !stop) begin
      prescaler_nxt = (prescaler == PS_LAST) ? '0 : prescaler + PW'(1);
      if (tick) begin
        if (!at_term) begin
          count_nxt  = inc_bcd_out;
          cnt_change = 1'b1;
        end else if (WRAP) begin
          count_nxt  = 16'h0000;
          cnt_change = 1'b1;
        end
      end
    end
  end

  // Datapath registers. A change in the same cycle as acceptance wins, so the
  // writer always ends up seeing the newest value.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      count     <= 16'h0000;
      upd_valid <= 1'b0;
    end else begin
      prescaler <= prescaler_nxt;
      count     <= count_nxt;
      if (cnt_change)     upd_valid <= 1'b1;
      else if (upd_ready) upd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_count_sequencer.sv
module tb_bcd_count_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, stop, clear, upd_ready;
  logic [15:0] inc_in  [3];
  logic [15:0] inc_out [3];
  logic        ie      [3];
  logic [15:0] cnt     [3];
  logic        run     [3];
  logic        dn      [3];
  logic        uv      [3];

  localparam int          P_PS [3] = '{4, 4, 1};
  localparam logic [15:0] P_T  [3] = '{16'h9999, 16'h0012, 16'h0012};
  localparam bit          P_W  [3] = '{1'b1, 1'b0, 1'b1};

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
        else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // External incrementers.
  assign inc_out[0] = bcd_inc(inc_in[0]);
  assign inc_out[1] = bcd_inc(inc_in[1]);
  assign inc_out[2] = bcd_inc(inc_in[2]);

  bcd_count_sequencer #(.PRESCALE(4), .TERMINAL(16'h9999), .WRAP(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .inc_bcd_in(inc_in[0]), .inc_enable(ie[0]), .inc_bcd_out(inc_out[0]),
    .count(cnt[0]), .running(run[0]), .done(dn[0]),
    .upd_valid(uv[0]), .upd_ready(upd_ready));

  bcd_count_sequencer #(.PRESCALE(4), .TERMINAL(16'h0012), .WRAP(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .inc_bcd_in(inc_in[1]), .inc_enable(ie[1]), .inc_bcd_out(inc_out[1]),
    .count(cnt[1]), .running(run[1]), .done(dn[1]),
    .upd_valid(uv[1]), .upd_ready(upd_ready));

  bcd_count_sequencer #(.PRESCALE(1), .TERMINAL(16'h0012), .WRAP(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .inc_bcd_in(inc_in[2]), .inc_enable(ie[2]), .inc_bcd_out(inc_out[2]),
    .count(cnt[2]), .running(run[2]), .done(dn[2]),
    .upd_valid(uv[2]), .upd_ready(upd_ready));

  // Reference model state, one slot per instance.
  int          m_state [3] = '{M_IDLE, M_IDLE, M_IDLE};
  int          m_ps    [3] = '{0, 0, 0};
  logic [15:0] m_count [3] = '{16'h0, 16'h0, 16'h0};
  logic        m_valid [3] = '{1'b0, 1'b0, 1'b0};

  // Scoreboard entry: {count, running, done, upd_valid} per instance.
  typedef logic [2:0][18:0] exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs: check combinational
  // outputs, advance the model, queue its prediction, then compare after the edge.
  task automatic step();
    exp_t e;
    logic tick;
    logic chg;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick = (m_state[i] == M_RUN) && !clear && !stop && (m_ps[i] == P_PS[i] - 1);
      check_val($sformatf("inc_enable[%0d]", i), 32'(ie[i]), 32'(tick));
      check_val($sformatf("inc_bcd_in[%0d]", i), 32'(inc_in[i]), 32'(m_count[i]));
      if (rst) begin
        m_state[i] = M_IDLE;
        m_ps[i]    = 0;
        m_count[i] = 16'h0000;
        m_valid[i] = 1'b0;
      end else begin
        chg = 1'b0;
        if (clear) begin
          m_state[i] = M_IDLE;
          m_ps[i]    = 0;
          m_count[i] = 16'h0000;
          chg        = 1'b1;
        end else if (stop) begin
          if (m_state[i] == M_RUN) m_state[i] = M_IDLE;
        end else if (m_state[i] == M_IDLE) begin
          if (start) m_state[i] = M_RUN;
        end else if (m_state[i] == M_RUN) begin
          m_ps[i] = (m_ps[i] == P_PS[i] - 1) ? 0 : m_ps[i] + 1;
          if (tick) begin
            if (m_count[i] != P_T[i]) begin
              m_count[i] = bcd_inc(m_count[i]);
              chg = 1'b1;
            end else if (P_W[i]) begin
              m_count[i] = 16'h0000;
              chg = 1'b1;
            end else begin
              m_state[i] = M_DONE;
            end
          end
        end
        if (chg) m_valid[i] = 1'b1;
        else if (upd_ready) m_valid[i] = 1'b0;
      end
      e[i] = {m_count[i], m_state[i] == M_RUN, m_state[i] == M_DONE, m_valid[i]};
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    for (int i = 0; i < 3; i++)
      check_val($sformatf("regs[%0d]", i), 32'({cnt[i], run[i], dn[i], uv[i]}), 32'(e[i]));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_count(input logic [15:0] v, input int budget);
    int n;
    n = 0;
    while (cnt[0] !== v && n < budget) begin
      step();
      n++;
    end
    check_val($sformatf("reach_%h", v), 32'(cnt[0]), 32'(v));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; upd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step();
    check_val("reset_count", 32'(cnt[0]), 32'h0000);
    check_val("reset_running", 32'(run[0]), 32'h0);
    check_val("reset_done", 32'(dn[0]), 32'h0);
    check_val("reset_valid", 32'(uv[0]), 32'h0);
    rst = 1'b0;

    clear = 1'b1; step(); clear = 1'b0;
    check_val("clear_valid", 32'(uv[0]), 32'h1);

    // RUN entry; first tick lands four cycles later.
    start = 1'b1; step();
    check_val("run_entry", 32'(run[0]), 32'h1);
    steps(3);
    check_val("first_cnt_hold", 32'(cnt[0]), 32'h0000);
    check_val("first_tick_en", 32'(ie[0]), 32'h1);
    step();
    check_val("first_cnt", 32'(cnt[0]), 32'h0001);
    check_val("tick_pulse_end", 32'(ie[0]), 32'h0);

    wait_count(16'h0009, 200);
    steps(4);
    check_val("carry_0010", 32'(cnt[0]), 32'h0010);

    // WRAP=0 instance: 0012 reached at RUN cycle 48, terminal tick at 52.
    steps(11);
    check_val("term_run_before", 32'({run[1], dn[1]}), 32'h2);
    step();
    check_val("term_done", 32'({run[1], dn[1]}), 32'h1);
    check_val("term_count", 32'(cnt[1]), 32'h0012);
    check_val("term_no_valid", 32'(uv[1]), 32'h0);
    steps(4);
    check_val("done_start_ignored", 32'({cnt[1], dn[1]}), 32'h00025);

    wait_count(16'h0099, 2000);
    steps(4);
    check_val("carry_0100", 32'(cnt[0]), 32'h0100);
    wait_count(16'h0999, 5000);
    steps(4);
    check_val("carry_1000", 32'(cnt[0]), 32'h1000);
    wait_count(16'h9999, 40000);
    steps(4);
    check_val("wrap_count", 32'(cnt[0]), 32'h0000);
    check_val("wrap_running", 32'(run[0]), 32'h1);
    check_val("wrap_valid", 32'(uv[0]), 32'h1);

    // Pause with prescaler at 2 (stop and start together gives IDLE).
    steps(2);
    stop = 1'b1; step(); stop = 1'b0;
    check_val("stop_idle", 32'(run[0]), 32'h0);
    step();
    check_val("resume_run", 32'(run[0]), 32'h1);
    check_val("resume_no_tick", 32'(ie[0]), 32'h0);
    step();
    check_val("resume_tick", 32'(ie[0]), 32'h1);
    step();
    check_val("resume_count", 32'(cnt[0]), 32'h0001);

    // Handshake stall across three ticks.
    upd_ready = 1'b0; steps(12);
    check_val("stall_count", 32'(cnt[0]), 32'h0004);
    check_val("stall_valid", 32'(uv[0]), 32'h1);
    upd_ready = 1'b1; step();
    check_val("accept_drop", 32'(uv[0]), 32'h0);
    upd_ready = 1'b0; steps(3);
    check_val("stall2_valid", 32'({cnt[0], uv[0]}), 32'h0000b);
    steps(3);
    upd_ready = 1'b1;
    check_val("coincide_tick", 32'(ie[0]), 32'h1);
    step();
    check_val("coincide_valid", 32'({cnt[0], uv[0]}), 32'h0000d);
    step();
    check_val("after_accept", 32'(uv[0]), 32'h0);

    // Clear leaves DONE; then reset mid-RUN at 0457.
    clear = 1'b1; step(); clear = 1'b0;
    check_val("clear_done", 32'({cnt[1], run[1], dn[1], uv[1]}), 32'h00001);
    step();
    wait_count(16'h0457, 3000);
    rst = 1'b1; step(); rst = 1'b0; start = 1'b0;
    #1;
    check_val("rst_mid_regs", 32'({cnt[0], run[0], dn[0], uv[0]}), 32'h00000);
    check_val("rst_mid_enable", 32'(ie[0]), 32'h0);
    steps(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
